// File: rtl/image_pkg.sv
// Shared pixel/image definitions for the resizing pipeline: default frame
// geometry, 24-bit BMP pixel packing and the streamer FSM state encoding.
package image_pkg;

    localparam int DEF_WIDTH  = 384;
    localparam int DEF_HEIGHT = 256;

    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    // Field order mirrors the BMP word layout, so a pixel_t cast of the raw word is exact.
    typedef struct packed {
        logic [CH_W-1:0] b;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] r;
    } pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_READ,
        ST_BLANK,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic pixel_t unpack_pixel(input logic [PIX_W-1:0] word);
        pixel_t p;
        p.r = word[R_LSB +: CH_W];
        p.g = word[G_LSB +: CH_W];
        p.b = word[B_LSB +: CH_W];
        return p;
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Bottom-up raster walker: row/col counters, row base register and the
// inter-line blank counter, producing the word address of the next pixel.
module raster_addr_gen #(
    parameter int WIDTH  = 384,
    parameter int HEIGHT = 256,
    parameter int HBLANK = 0,
    parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              step,
    input  logic              blank_clr,
    input  logic              blank_inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row,
    output logic              blank_last
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [ADDR_W-1:0] TOP    = ADDR_W'((HEIGHT-1)*WIDTH);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WIDTH);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] base;
    logic [BLK_W-1:0]  bcnt;

    assign last_col   = (32'(col)  == WIDTH  - 1);
    assign last_row   = (32'(row)  == HEIGHT - 1);
    assign blank_last = (32'(bcnt) == HBLANK - 1);

    // addr is kept equal to base+col incrementally, so no adder on the row path
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col  <= '0;
            row  <= '0;
            base <= TOP;
            addr <= '0;
        end else if (restart) begin
            col  <= '0;
            row  <= '0;
            base <= TOP;
            addr <= TOP;
        end else if (step && !(last_col && last_row)) begin
            if (last_col) begin
                col  <= '0;
                row  <= row + ROW_W'(1);
                base <= base - STRIDE;
                addr <= base - STRIDE;
            end else begin
                col  <= col + COL_W'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcnt <= '0;
        end else if (blank_clr) begin
            bcnt <= '0;
        end else if (blank_inc) begin
            bcnt <= bcnt + BLK_W'(1);
        end
    end

endmodule

// File: rtl/input_streamer.sv
// Streams a bottom-up BMP pixel array top-down, one pixel per cycle, with
// programmable start delay and inter-line blanking; 2-cycle read/output pipe.
module input_streamer
    import image_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int START_DELAY = 4,
    parameter int HBLANK      = 0,
    parameter int ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [CH_W-1:0]   r,
    output logic [CH_W-1:0]   g,
    output logic [CH_W-1:0]   b,
    output logic              horizontal_sync,
    output logic              done
);

    // One counter serves both the start delay and the 2-cycle flush.
    localparam int CNT_MAX = (START_DELAY > 2) ? START_DELAY : 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             restart, step, blank_clr, blank_inc;
    logic             last_col, last_row, blank_last;
    logic             rd_valid;
    pixel_t           pix;

    always_comb begin
        restart   = 1'b0;
        step      = 1'b0;
        blank_clr = 1'b0;
        blank_inc = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: restart = start;
            ST_READ: begin
                step      = 1'b1;
                blank_clr = last_col;
            end
            ST_BLANK: blank_inc = !blank_last;
            default: ;
        endcase
    end

    raster_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .HBLANK (HBLANK),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .step       (step),
        .blank_clr  (blank_clr),
        .blank_inc  (blank_inc),
        .addr       (mem_addr),
        .last_col   (last_col),
        .last_row   (last_row),
        .blank_last (blank_last)
    );

    // mem_rden is registered alongside every transition into or out of READ
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mem_rden <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done <= 1'b0;
                        cnt  <= '0;
                        if (START_DELAY == 0) begin
                            state    <= ST_READ;
                            mem_rden <= 1'b1;
                        end else begin
                            state <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt == CNT_W'(START_DELAY - 1)) begin
                        state    <= ST_READ;
                        mem_rden <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    if (last_col) begin
                        if (last_row) begin
                            state    <= ST_FLUSH;
                            mem_rden <= 1'b0;
                            cnt      <= '0;
                        end else if (HBLANK > 0) begin
                            state    <= ST_BLANK;
                            mem_rden <= 1'b0;
                        end
                    end
                end
                ST_BLANK: begin
                    if (blank_last) begin
                        state    <= ST_READ;
                        mem_rden <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    mem_rden <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid        <= 1'b0;
            horizontal_sync <= 1'b0;
            pix             <= '0;
        end else begin
            rd_valid        <= mem_rden;
            horizontal_sync <= rd_valid;
            if (rd_valid) begin
                pix <= unpack_pixel(mem_rdata);
            end
        end
    end

    assign r = pix.r;
    assign g = pix.g;
    assign b = pix.b;

endmodule

// File: doc/input_streamer.md
# input_streamer

Pixel source at the head of the resizing pipeline: reads a bottom-up BMP pixel array from an external pixel memory and streams it top-down, one 24-bit pixel per cycle, on the `r`/`g`/`b`/`horizontal_sync` bus consumed by the upscaling/output stage. It sequences rows, inserts programmable start and inter-line gaps, and asserts `done` after the last pixel has left the output registers.

## Interface
- `WIDTH`, 384: pixels per source row.
- `HEIGHT`, 256: source rows.
- `START_DELAY`, 4: idle cycles between accepted `start` and first address issue; 0 allowed.
- `HBLANK`, 0: idle cycles between the last address of one row and the first of the next; 0 means gapless.
- `ADDR_W`, $clog2(WIDTH*HEIGHT): pixel memory address width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request to begin a frame; ignored unless in IDLE or DONE.
- `mem_addr` out ADDR_W: pixel word address.
- `mem_rden` out 1: read strobe for `mem_addr`.
- `mem_rdata` in 24: pixel word {B[23:16], G[15:8], R[7:0]} (BMP byte order), valid exactly one cycle after `mem_rden`.
- `r`, `g`, `b` out 8 each: registered pixel channels.
- `horizontal_sync` out 1: pixel-valid strobe, high for exactly WIDTH*HEIGHT cycles per frame.
- `done` out 1: frame complete, level.

## Operation
- FSM states: IDLE, DELAY, READ, BLANK, FLUSH, DONE.
- IDLE/DONE + `start` -> DELAY (or directly READ if START_DELAY=0); clears `done`, row=0, col=0, delay counter=0.
- DELAY: count to START_DELAY-1, then READ.
- READ: `mem_rden`=1, `mem_addr` = (HEIGHT-1-row)*WIDTH + col. col increments; at col=WIDTH-1: col<=0, row<=row+1; then BLANK if HBLANK>0 and row not last, FLUSH if row=HEIGHT-1, else stay in READ.
- BLANK: `mem_rden`=0 for HBLANK cycles, then READ.
- FLUSH: wait 2 cycles for the pipeline to drain, then DONE.
- DONE: `done`=1, holds until `start` or reset.
- Data path: stage 1 registers `mem_rden` as rd_valid; stage 2 registers `r`<=`mem_rdata`[7:0], `g`<=[15:8], `b`<=[23:16], `horizontal_sync`<=rd_valid. When rd_valid=0, channels hold their last value.
- Address computed with row base register (base -= WIDTH per row, starting at (HEIGHT-1)*WIDTH) plus col; no multiplier.
- Counters: col width $clog2(WIDTH), row width $clog2(HEIGHT); no wrap beyond last pixel.

## Timing
- Reset (asserted anywhere, including mid-frame): state IDLE, `mem_addr`=0, `mem_rden`=0, `r`=`g`=`b`=0, `horizontal_sync`=0, `done`=0; pipeline valid bits cleared, so no partial pixel is emitted after release.
- Latency: `start` at cycle 0 -> first `mem_rden` at cycle 1+START_DELAY -> first `horizontal_sync` at cycle 3+START_DELAY.
- Address-to-output latency 2 cycles; throughput 1 pixel/cycle inside a row.
- Frame length from first to last `horizontal_sync`: WIDTH*HEIGHT + (HEIGHT-1)*HBLANK cycles.
- `done` rises the cycle after the last `horizontal_sync` falls, so it is never high together with `horizontal_sync`.
- `start` during DELAY/READ/BLANK/FLUSH is ignored; `start` in the same cycle `done` is high restarts cleanly, and `done` drops the next cycle.

## Structure
- Shared package `image_pkg`: default WIDTH/HEIGHT, pixel struct {b,g,r}, the 24-bit packing constants, and the FSM state enum, so the output stage and benches use the same definitions.
- One natural sub-module: `raster_addr_gen` (row/col counters, base register, BLANK counter, end-of-row/end-of-frame flags); the top keeps the FSM and 2-stage output pipe.

## Test plan
- WIDTH=4, HEIGHT=2, START_DELAY=2, HBLANK=0, memory word n = n: `start` at cycle 0 -> `horizontal_sync` cycles 5–12, R sequence 4,5,6,7,0,1,2,3; `done`=1 at cycle 13.
- Same with HBLANK=3 -> `horizontal_sync` high cycles 5–8 and 12–15, low 9–11; `done` at cycle 16.
- START_DELAY=0 -> first `mem_rden` cycle 1, first `horizontal_sync` cycle 3.
- Word 0xAABBCC -> R=0xCC, G=0xBB, B=0xAA.
- `start` pulsed again mid-READ -> ignored, exactly 8 `horizontal_sync` pulses; `start` in DONE -> second identical frame, `done` low the cycle after.
- `reset` low mid-row 1 -> all outputs 0 within the same cycle, no `horizontal_sync` after release until a new `start`, and the new frame begins at address (HEIGHT-1)*WIDTH.
